// File: rtl/generators.sv
// Generators: 16-bit Fibonacci LFSR that publishes a registered 4-bit
// pseudo-random value, optionally forcing consecutive values to differ.
module generators #(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
   parameter bit          NO_REPEAT    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic [3:0]  result,
   output logic        valid
);

   logic [15:0] lfsr;
   logic [15:0] lfsr_next;
   logic        fb;
   logic [3:0]  cand;
   logic [3:0]  pub;

   // Next LFSR state from taps 16,14,13,11, and the value to publish; when
   // repeats are suppressed a candidate equal to the current result is bumped
   // by one (wrapping F to 0) so two consecutive results can never match.
   always_comb begin
      fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      lfsr_next = {lfsr[14:0], fb};
      cand      = lfsr_next[3:0];
      pub       = cand;
      if (NO_REPEAT && (cand == result)) begin
         pub = cand + 4'd1;
      end
   end

   // State update: reset beats seed load, which beats a normal step. A zero
   // seed would lock the LFSR, so it is replaced by the default seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr   <= SEED_DEFAULT;
         result <= 4'h0;
         valid  <= 1'b0;
      end else if (seed_load) begin
         lfsr  <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
         valid <= 1'b0;
      end else if (enable) begin
         lfsr   <= lfsr_next;
         result <= pub;
         valid  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_generators.sv
// Self-checking bench for generators: directed checks of the known sequence
// plus randomized control traffic compared against a behavioural model.
module tb_generators;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [3:0]  result;
   logic        valid;

   int tests = 0;
   int fails = 0;

   logic [15:0] mLfsr;
   logic [3:0]  mResult;
   logic        mValid;

   generators #(.SEED_DEFAULT(16'hACE1), .NO_REPEAT(1'b1)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .seed_load(seed_load),
      .seed(seed),
      .result(result),
      .valid(valid)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference step: parity of the tapped bits shifted in at the bottom.
   function automatic logic [15:0] advance(input logic [15:0] s);
      int ones;
      ones = $countones(s & 16'hB400);
      return ((s << 1) & 16'hFFFF) | 16'(ones % 2);
   endfunction

   // Behavioural model of one clock edge given the sampled controls.
   task automatic modelStep(input logic r, input logic sl, input logic en,
                            input logic [15:0] sd);
      logic [15:0] n;
      logic [3:0]  c;
      if (r) begin
         mLfsr = 16'hACE1; mResult = 4'h0; mValid = 1'b0;
      end else if (sl) begin
         mLfsr  = (sd == 16'h0000) ? 16'hACE1 : sd;
         mValid = 1'b0;
      end else if (en) begin
         n = advance(mLfsr);
         c = n[3:0];
         mResult = (c == mResult) ? 4'((int'(c) + 1) % 16) : c;
         mLfsr   = n;
         mValid  = 1'b1;
      end
   endtask

   // Drive controls, let one edge pass, then update the model.
   task automatic applyStimulus(input logic r, input logic sl, input logic en,
                                input logic [15:0] sd);
      rst = r; seed_load = sl; enable = en; seed = sd;
      @(posedge clk);
      #1;
      modelStep(r, sl, en, sd);
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".result"}, 32'(result), 32'(mResult));
      checkOutput({tag, ".valid"},  32'(valid),  32'(mValid));
      checkOutput({tag, ".lfsr"},   32'(dut.lfsr), 32'(mLfsr));
   endtask

   task automatic checkFixed(input string tag, input logic [3:0] r,
                             input logic v, input logic [15:0] l);
      checkOutput({tag, ".result"}, 32'(result), 32'(r));
      checkOutput({tag, ".valid"},  32'(valid),  32'(v));
      checkOutput({tag, ".lfsr"},   32'(dut.lfsr), 32'(l));
   endtask

   initial begin
      logic [3:0]  prev;
      logic [15:0] held;
      logic        sawRepeat;
      logic        sawZero;
      logic        earlyReturn;
      logic        r, sl, en;
      logic [15:0] sd;

      mLfsr = 16'h0000; mResult = 4'h0; mValid = 1'b0;
      @(negedge clk);

      // Reset state and the first two steps of the known sequence.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkFixed("reset", 4'h0, 1'b0, 16'hACE1);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkFixed("step1", 4'h3, 1'b1, 16'h59C3);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkFixed("step2", 4'h7, 1'b1, 16'hB387);

      // Holding with enable low, then resuming with no skipped step.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
         checkFixed("hold", 4'h7, 1'b1, 16'hB387);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkFixed("resume", mResult, 1'b1, advance(16'hB387));
      checkModel("resume.model");

      // Zero seed is replaced by the default seed.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkFixed("seed0", 4'h0, 1'b0, 16'hACE1);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkFixed("seed0.step", 4'h3, 1'b1, 16'h59C3);

      // Seed load wins over enable and leaves result untouched.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
      checkFixed("loadwins", 4'h3, 1'b0, 16'h1234);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkModel("afterload");

      // Reset mid-run with enable high restarts the power-on sequence.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'hBEEF);
      checkFixed("midreset", 4'h0, 1'b0, 16'hACE1);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkFixed("midreset.step1", 4'h3, 1'b1, 16'h59C3);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      checkFixed("midreset.step2", 4'h7, 1'b1, 16'hB387);

      // Randomized control traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         r  = ($urandom_range(63) == 0);
         sl = ($urandom_range(15) == 0);
         en = ($urandom_range(1) == 1);
         sd = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
         applyStimulus(r, sl, en, sd);
         checkModel("random");
      end

      // Full period with enable held: no repeats, never zero, returns home.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      held = dut.lfsr;
      prev = result;
      sawRepeat = 1'b0; sawZero = 1'b0; earlyReturn = 1'b0;
      for (int i = 1; i <= 65535; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
         if (result == prev) sawRepeat = 1'b1;
         if (dut.lfsr == 16'h0000) sawZero = 1'b1;
         if (i < 65535 && dut.lfsr == 16'hACE1) earlyReturn = 1'b1;
         prev = result;
         if (i % 64 == 0) checkModel("period");
      end
      checkOutput("period.start", 32'(held), 32'(16'hACE1));
      checkOutput("period.return", 32'(dut.lfsr), 32'(16'hACE1));
      checkOutput("period.norepeat", 32'(sawRepeat), 32'(1'b0));
      checkOutput("period.nonzero", 32'(sawZero), 32'(1'b0));
      checkOutput("period.early", 32'(earlyReturn), 32'(1'b0));
      checkModel("period.end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/generators.md
GENERATORS -- requirements
Module: generators

Interface
REQ-001 Parameter SEED_DEFAULT, 16'hACE1, LFSR state loaded by reset and substituted for an all-zero seed.
REQ-002 Parameter NO_REPEAT, 1, when 1 consecutive published results never repeat.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  when high, advance generator one step per clock.
REQ-006 seed_load  input  1  when high, load seed into LFSR.
REQ-007 seed  input  16  seed value sampled when seed_load=1.
REQ-008 result  output  4  current pseudo-random value (registered).
REQ-009 valid  output  1  high once result holds a generated value.

Function
REQ-010 State: 16-bit register lfsr, 4-bit register result, 1-bit register valid.
REQ-011 Feedback fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]; maximal-length polynomial x^16+x^14+x^13+x^11+1.
REQ-012 Step: lfsr_next = {lfsr[14:0], fb}; period 65535; all-zero state unreachable.
REQ-013 Candidate cand = lfsr_next[3:0].
REQ-014 NO_REPEAT=1: if cand == result, publish (cand + 1) mod 16 (4'hF wraps to 4'h0); else publish cand.
REQ-015 NO_REPEAT=0: publish cand unconditionally.
REQ-016 enable=1 and seed_load=0 on a clock edge: lfsr <= lfsr_next, result <= published value, valid <= 1.
REQ-017 Update latency: one clock; result changes at the same edge that samples enable=1.
REQ-018 enable=0 and seed_load=0: lfsr, result and valid hold.
REQ-019 seed_load=1: lfsr <= (seed == 0) ? SEED_DEFAULT : seed; result holds; valid <= 0; enable ignored that cycle.
REQ-020 Priority: rst > seed_load > enable.
REQ-021 No combinational path from inputs to outputs.

Reset
REQ-022 On a clock edge with rst=1: lfsr <= SEED_DEFAULT, result <= 4'h0, valid <= 0.
REQ-023 rst=1 overrides seed_load and enable in the same cycle.
REQ-024 Reset mid-sequence: the sequence after reset is identical to the sequence after power-on reset.

Verification
REQ-025 Reset, then enable=1 for 2 clocks -> result 4'h3 (lfsr 16'h59C3), then 4'h7 (lfsr 16'hB387); valid goes 0 -> 1 on the first step.
REQ-026 After REQ-025, enable=0 for 8 clocks -> result stays 4'h7 and lfsr stays 16'hB387; enable=1 resumes the exact sequence with no skipped step.
REQ-027 seed_load=1 with seed=0 -> lfsr = 16'hACE1 and valid=0; the next enabled step gives result 4'h3 (previous result 4'h0).
REQ-028 seed_load=1 and enable=1 in the same cycle -> load wins; lfsr = seed and result is unchanged.
REQ-029 NO_REPEAT=1, enable held 65535 clocks -> no two consecutive results equal; lfsr returns to its start value at step 65535 and is never 0.
REQ-030 rst asserted mid-run with enable=1 -> next edge gives result 4'h0, valid=0, lfsr 16'hACE1; the sequence then matches REQ-025.
